// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control sequencer for the ARM-subset datapath (DP, LDR/STR, B) with NZCV and wait-state timeout.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counter ports.
module arm_multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int PERF_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        adr_src,
    output logic        reg_write,
    output logic [1:0]  reg_src,
    output logic [1:0]  imm_src,
    output logic        alu_src,
    output logic [2:0]  alu_control,
    output logic        mov,
    output logic        mem_to_reg,
    output logic [3:0]  flags,
    output logic        mem_err,
    output logic        illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
    } state_t;

    localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit            TO_EN   = (TIMEOUT_CYC > 0);

    if (PERF_W < 1 || TIMEOUT_CYC < 0) begin : g_param_chk
        $error("arm_multicycle_ctrl: bad PERF_W or TIMEOUT_CYC");
    end

    state_t        state;
    logic [3:0]    flags_q;
    logic [TW-1:0] to_cnt;

    logic [1:0] op;
    logic [3:0] cmd, cond;
    logic       ibit, sbit;
    assign op   = instr[27:26];
    assign ibit = instr[25];
    assign cmd  = instr[24:21];
    assign sbit = instr[20];
    assign cond = instr[31:28];

    logic unused_instr;
    assign unused_instr = ^instr[19:0];

    logic cond_ok;
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = !flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = !flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = !flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = !flags_q[0];
            4'b1000: cond_ok = flags_q[1] && !flags_q[2];
            4'b1001: cond_ok = !flags_q[1] || flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic       cmd_ok, is_cmp, is_logic, dp_mov;
    logic [2:0] dp_ctl;
    always_comb begin
        cmd_ok = 1'b1;
        dp_ctl = 3'b000;
        dp_mov = 1'b0;
        case (cmd)
            4'b0100:          dp_ctl = 3'b000;
            4'b0010, 4'b1010: dp_ctl = 3'b001;
            4'b0000:          dp_ctl = 3'b010;
            4'b1100:          dp_ctl = 3'b011;
            4'b1101:          dp_mov = 1'b1;
            default:          cmd_ok = 1'b0;
        endcase
    end
    assign is_cmp   = (cmd == 4'b1010);
    // Logical ops and MOV leave carry/overflow alone even when setting flags.
    assign is_logic = (cmd == 4'b0000) || (cmd == 4'b1100) || (cmd == 4'b1101);

    logic access, waiting, timeout, bad_op;
    assign access  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign waiting = access && !mem_ready;
    assign timeout = TO_EN && waiting && (to_cnt == TO_LAST);
    assign bad_op  = cond_ok && ((op == 2'b11) || ((op == 2'b00) && !cmd_ok));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH;
            flags_q <= '0;
            to_cnt  <= '0;
        end else begin
            to_cnt <= (TO_EN && waiting && !timeout) ? to_cnt + 1'b1 : '0;
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (!cond_ok) state <= S_FETCH;
                    else begin
                        case (op)
                            2'b00:   state <= cmd_ok ? S_EXEC : S_FETCH;
                            2'b01:   state <= S_MEMADR;
                            2'b10:   state <= S_BRANCH;
                            default: state <= S_FETCH;
                        endcase
                    end
                end
                S_EXEC: begin
                    if (sbit || is_cmp) begin
                        flags_q[3:2] <= alu_flags[3:2];
                        if (!is_logic) flags_q[1:0] <= alu_flags[1:0];
                    end
                    state <= is_cmp ? S_FETCH : S_ALUWB;
                end
                S_MEMADR: state <= sbit ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready)    state <= S_MEMWB;
                    else if (timeout) state <= S_FETCH;
                end
                S_MEMWR:  if (mem_ready || timeout) state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Reset gates every output combinationally so an access is dropped in the reset cycle itself.
    always_comb begin
        {mem_req, mem_we, ir_write, pc_write, pc_src, adr_src, reg_write} = '0;
        {reg_src, imm_src, alu_src, alu_control, mov, mem_to_reg, illegal} = '0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: illegal = bad_op;
            S_EXEC: begin
                alu_src     = ibit;
                alu_control = dp_ctl;
                mov         = dp_mov;
            end
            S_ALUWB: reg_write = 1'b1;
            S_MEMADR: begin
                alu_src = 1'b1;
                imm_src = 2'b01;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                reg_src = 2'b10;
            end
            S_BRANCH: begin
                reg_src  = 2'b01;
                imm_src  = 2'b10;
                alu_src  = 1'b1;
                pc_write = 1'b1;
                pc_src   = 1'b1;
            end
            default: ;
        endcase
        mem_err = timeout;
        flags   = flags_q;
        if (!reset) begin
            {mem_req, mem_we, ir_write, pc_write, pc_src, adr_src, reg_write} = '0;
            {reg_src, imm_src, alu_src, alu_control, mov, mem_to_reg, illegal} = '0;
            mem_err = 1'b0;
            flags   = '0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_q, ins_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (state == S_DECODE && !bad_op) ins_q <= ins_q + 1'b1;
        end
    end
    assign cycle_cnt = reset ? cyc_q : '0;
    assign instr_cnt = reset ? ins_q : '0;
`endif

endmodule
